// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default sizing,
// control state encoding and a period helper.
package clk_div_pkg;

    // Default counter / divisor width.
    localparam int CLK_DIV_CNT_W   = 16;
    // Default half-period terminal count: 2*(70+1) = 142 clk_in cycles.
    localparam int CLK_DIV_DEFAULT = 70;

    // Divider control states: run enable crossed with update pending.
    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_RUN_PEND  = 2'b01,
        ST_HOLD      = 2'b10,
        ST_HOLD_PEND = 2'b11
    } div_state_e;

    // Full output period in clk_in cycles for half-period terminal count t.
    function automatic int unsigned div_period(input int unsigned t);
        return 2 * (t + 1);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: half-period counter, terminal compare, output toggle
// and registered tick strobes. The terminal count is supplied by the top.
module clk_div_core #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             clk_rst,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] cur_div,
    output logic             term,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_any
);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_any_q, tick_any_d;
    logic             hit;

    // Counter never exceeds cur_div, so equality alone marks the terminal count.
    always_comb begin
        hit         = (counter_q == cur_div);
        term        = en && hit;
        counter_d   = counter_q;
        clk_out_d   = clk_out_q;
        tick_rise_d = 1'b0;
        tick_any_d  = 1'b0;
        if (clear) begin
            counter_d = '0;
        end else if (en) begin
            if (hit) begin
                counter_d   = '0;
                clk_out_d   = ~clk_out_q;
                tick_any_d  = 1'b1;
                tick_rise_d = ~clk_out_q;
            end else begin
                counter_d = counter_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (clk_rst) begin
            counter_q   <= '0;
            clk_out_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_any_q  <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            clk_out_q   <= clk_out_d;
            tick_rise_q <= tick_rise_d;
            tick_any_q  <= tick_any_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick_rise = tick_rise_q;
    assign tick_any  = tick_any_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider. Holds the divisor shadow register,
// the valid/ready handshake and the rule for when a new divisor is applied.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | counting, no divisor update waiting
// RUN_PEND  | counting, update applied at the next terminal count
// HOLD      | frozen, no divisor update waiting
// HOLD_PEND | frozen, update applied on the next edge (counter cleared)
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DIV_DEFAULT = CLK_DIV_DEFAULT
) (
    input  logic             clk_in,
    input  logic             clk_rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_value,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_any,
    output logic [CNT_W-1:0] cur_div
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             div_ready_q, div_ready_d;
    logic             pending;
    logic             pending_next;
    logic             xfer;
    logic             clear;
    logic             term;

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in    (clk_in),
        .clk_rst   (clk_rst),
        .en        (en),
        .clear     (clear),
        .cur_div   (cur_div_q),
        .term      (term),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_any  (tick_any)
    );

    // Handshake acceptance and divisor apply decisions; next state follows en.
    always_comb begin
        pending      = (state_q == ST_RUN_PEND) || (state_q == ST_HOLD_PEND);
        xfer         = div_valid && div_ready_q;
        shadow_d     = shadow_q;
        cur_div_d    = cur_div_q;
        pending_next = pending;
        clear        = 1'b0;
        case (state_q)
            ST_RUN, ST_HOLD: begin
                // A transfer coinciding with a terminal count is only
                // recorded here, so it waits for the following terminal.
                if (xfer) begin
                    shadow_d     = div_value;
                    pending_next = 1'b1;
                end
            end
            ST_RUN_PEND, ST_HOLD_PEND: begin
                if (!en) begin
                    cur_div_d    = shadow_q;
                    clear        = 1'b1;
                    pending_next = 1'b0;
                end else if (term) begin
                    // The finishing half-period used the old count.
                    cur_div_d    = shadow_q;
                    pending_next = 1'b0;
                end
            end
            default: begin
                pending_next = 1'b0;
            end
        endcase
        if (en) begin
            state_d = pending_next ? ST_RUN_PEND : ST_RUN;
        end else begin
            state_d = pending_next ? ST_HOLD_PEND : ST_HOLD;
        end
        div_ready_d = ~pending_next;
    end

    // Control registers with synchronous reset; reset drops any pending update.
    always_ff @(posedge clk_in) begin
        if (clk_rst) begin
            state_q     <= ST_RUN;
            shadow_q    <= '0;
            cur_div_q   <= CNT_W'(DIV_DEFAULT);
            div_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cur_div_q   <= cur_div_d;
            div_ready_q <= div_ready_d;
        end
    end

    assign div_ready = div_ready_q;
    assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a behavioural model pushes the expected
// outputs after every edge, a monitor pops and compares on the falling edge.
module tb_clk_div_prog;
    import clk_div_pkg::*;

    localparam int CNT_W = 16;
    localparam int DEF_T = 70;

    logic             clk_in = 1'b0;
    logic             clk_rst;
    logic             en;
    logic [CNT_W-1:0] div_value;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_any;
    logic [CNT_W-1:0] cur_div;

    typedef struct packed {
        logic             clk_out;
        logic             tick_rise;
        logic             tick_any;
        logic             div_ready;
        logic [CNT_W-1:0] cur_div;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: half-period of length T+1 cycles, one pending update.
    int   m_t;
    int   m_done;
    bit   m_out;
    bit   m_pend;
    int   m_shadow;
    bit   m_rise;
    bit   m_any;

    clk_div_prog #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DEF_T)
    ) dut (
        .clk_in    (clk_in),
        .clk_rst   (clk_rst),
        .en        (en),
        .div_value (div_value),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_any  (tick_any),
        .cur_div   (cur_div)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_step();
        bit   accept;
        exp_t e;
        if (clk_rst) begin
            m_t = DEF_T; m_done = 0; m_out = 0; m_pend = 0;
            m_shadow = 0; m_rise = 0; m_any = 0;
        end else begin
            accept = div_valid && !m_pend;
            m_rise = 0;
            m_any  = 0;
            if (en) begin
                m_done++;
                if (m_done == m_t + 1) begin
                    m_any  = 1;
                    m_rise = !m_out;
                    m_out  = !m_out;
                    m_done = 0;
                    if (m_pend) begin
                        m_t    = m_shadow;
                        m_pend = 0;
                    end
                end
            end else if (m_pend) begin
                m_t    = m_shadow;
                m_done = 0;
                m_pend = 0;
            end
            if (accept) begin
                m_shadow = int'(div_value);
                m_pend   = 1;
            end
        end
        e.clk_out   = m_out;
        e.tick_rise = m_rise;
        e.tick_any  = m_any;
        e.div_ready = !m_pend;
        e.cur_div   = CNT_W'(m_t);
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bound_check(input bit ok, input string name);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: wait bound expired (got timeout, need condition)", name);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int g = 0; g < 1000 && m_pend; g++) cycle();
        bound_check(!m_pend, name);
    endtask

    task automatic wait_done(input int d, input string name);
        int budget;
        budget = int'(div_period(m_t)) + 8;
        for (int g = 0; g < budget && m_done != d; g++) cycle();
        bound_check(m_done == d, name);
    endtask

    task automatic write_div(input int v);
        div_valid = 1'b1;
        div_value = CNT_W'(v);
        cycle();
        div_valid = 1'b0;
        div_value = CNT_W'($urandom);
    endtask

    // Monitor: one comparison per edge the model has predicted.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (clk_out !== e.clk_out || tick_rise !== e.tick_rise ||
                    tick_any !== e.tick_any || div_ready !== e.div_ready ||
                    cur_div !== e.cur_div) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got clk_out=%b rise=%b any=%b ready=%b cur_div=%0d, need clk_out=%b rise=%b any=%b ready=%b cur_div=%0d",
                             $time, clk_out, tick_rise, tick_any, div_ready, cur_div,
                             e.clk_out, e.tick_rise, e.tick_any, e.div_ready, e.cur_div);
                end
            end
        end
    end

    initial begin
        clk_rst   = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_value = '0;
        run(2);
        clk_rst = 1'b0;

        // Default divisor: 142-cycle period.
        en = 1'b1;
        run(400);

        // Reprogram to 4 at count 30; old half-period finishes first.
        wait_ready("ready_before_4");
        wait_done(30, "reach_count_30");
        write_div(4);
        run(200);

        // Divisor 0: toggle every cycle.
        wait_ready("ready_before_0");
        write_div(0);
        run(50);

        // Transfer exactly on a terminal count with cur_div=9.
        wait_ready("ready_before_9");
        write_div(9);
        wait_ready("apply_9");
        run(25);
        wait_done(9, "reach_terminal_9");
        write_div(5);
        run(60);

        // Freeze at count 5 for 20 cycles, then resume.
        wait_ready("ready_before_70");
        write_div(70);
        wait_ready("apply_70");
        wait_done(5, "reach_count_5");
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(100);

        // Write during freeze: applied on the next edge with counter cleared.
        en = 1'b0;
        run(3);
        write_div(3);
        run(4);
        en = 1'b1;
        run(30);

        // Reset while an update is pending and clk_out is high.
        wait_ready("ready_before_rst");
        for (int g = 0; g < 200 && !m_out; g++) cycle();
        bound_check(m_out, "reach_clk_out_high");
        write_div(20);
        clk_rst = 1'b1;
        run(1);
        clk_rst = 1'b0;
        run(200);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            div_valid = ($urandom_range(0, 9) == 0);
            div_value = CNT_W'($urandom_range(0, 12));
            clk_rst   = ($urandom_range(0, 499) == 0);
            cycle();
        end
        clk_rst   = 1'b0;
        div_valid = 1'b0;
        en        = 1'b1;
        run(20);

        @(negedge clk_in);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
